// File: rtl/nf_ahb2apb_bridge.sv
// nf_ahb2apb_bridge: AHB-Lite slave to APB4 requester bridge.
// One APB transfer per accepted AHB NONSEQ/SEQ beat; hburst_s ignored.
// Ports:
//   hclk, hresetn (async, active-low)
//   AHB slave in : haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s,
//                  hburst_s, hsel_s
//   AHB slave out: hrdata_s, hresp_s, hready_s
//   APB4 out     : paddr, pwdata, pwrite, pstrb, psel, penable
//   APB4 in      : prdata, pready, pslverr
// Parameter apb_addr_w: haddr LSBs forwarded to paddr (upper bits 0).
// Macro NF_AHB2APB_ERR_EN: map pslverr to the two-cycle AHB ERROR
// response (ERR1/ERR2); without it pslverr is ignored.

module nf_ahb2apb_bridge #(
   parameter int apb_addr_w = 32
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [31:0] haddr_s,
   input  logic [31:0] hwdata_s,
   input  logic        hwrite_s,
   input  logic [1:0]  htrans_s,
   input  logic [2:0]  hsize_s,
   input  logic [2:0]  hburst_s,
   input  logic        hsel_s,
   output logic [31:0] hrdata_s,
   output logic [1:0]  hresp_s,
   output logic        hready_s,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic        pwrite,
   output logic [3:0]  pstrb,
   output logic        psel,
   output logic        penable,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   localparam logic [31:0] ADDR_MASK =
      (apb_addr_w >= 32) ? 32'hFFFF_FFFF :
      32'((64'd1 << apb_addr_w) - 64'd1);

   typedef enum logic [2:0] {
      IDLE,
      WDATA,
      SETUP,
`ifdef NF_AHB2APB_ERR_EN
      ACCESS,
      ERR1,
      ERR2
`else
      ACCESS
`endif
   } state_t;

   state_t      state;
   logic        apb_err;
   logic        accept;
   logic [3:0]  strb_d;
   logic        unused_ok;

`ifdef NF_AHB2APB_ERR_EN
   assign apb_err = pslverr;
`else
   assign apb_err = 1'b0;
`endif

   assign unused_ok = ^{hburst_s, htrans_s[0], pslverr};

   // hready_s is high only in states able to take a new address phase
   assign accept = hsel_s & htrans_s[1] & hready_s;

   always_comb begin
      strb_d = 4'b0000;
      if (hwrite_s) begin
         unique case (1'b1)
            (hsize_s >= 3'd2): strb_d = 4'b1111;
            (hsize_s == 3'd1): strb_d = 4'b0011 << {haddr_s[1], 1'b0};
            default:           strb_d = 4'b0001 << haddr_s[1:0];
         endcase
      end
   end

   // AHB data-phase response follows pready in the same cycle
   always_comb begin
      hready_s = 1'b1;
      hresp_s  = 2'b00;
      hrdata_s = '0;
      unique case (state)
         IDLE:  hready_s = 1'b1;
         WDATA: hready_s = 1'b0;
         SETUP: hready_s = 1'b0;
         ACCESS: begin
            hready_s = pready & ~apb_err;
            if (pready && !apb_err && !pwrite)
               hrdata_s = prdata;
         end
`ifdef NF_AHB2APB_ERR_EN
         ERR1: begin
            hready_s = 1'b0;
            hresp_s  = 2'b01;
         end
         ERR2: begin
            hready_s = 1'b1;
            hresp_s  = 2'b01;
         end
`endif
         default: hready_s = 1'b1;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state   <= IDLE;
         paddr   <= '0;
         pwdata  <= '0;
         pwrite  <= 1'b0;
         pstrb   <= 4'b0000;
         psel    <= 1'b0;
         penable <= 1'b0;
      end else begin
         unique case (state)
            IDLE: state <= IDLE;
            WDATA: begin
               pwdata  <= hwdata_s;
               psel    <= 1'b1;
               penable <= 1'b0;
               state   <= SETUP;
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
`ifdef NF_AHB2APB_ERR_EN
                  state   <= pslverr ? ERR1 : IDLE;
`else
                  state   <= IDLE;
`endif
               end
            end
`ifdef NF_AHB2APB_ERR_EN
            ERR1: state <= ERR2;
            ERR2: state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
         // a new address phase overrides the exit of IDLE/ACCESS/ERR2
         if (accept) begin
            paddr   <= haddr_s & ADDR_MASK;
            pwrite  <= hwrite_s;
            pstrb   <= strb_d;
            psel    <= ~hwrite_s;
            penable <= 1'b0;
            state   <= hwrite_s ? WDATA : SETUP;
         end
      end
   end

endmodule

// File: doc/nf_ahb2apb_bridge.md
NF_AHB2APB_BRIDGE -- requirements
Module: nf_ahb2apb_bridge

Interface
REQ-001 The block SHALL have parameter apb_addr_w, default 32, meaning the number of haddr LSBs forwarded to paddr; the upper paddr bits are zero.
REQ-002 The block SHALL have port hclk, input, 1 bit: the single clock for all state.
REQ-003 The block SHALL have port hresetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have AHB slave inputs:
- haddr_s, input, 32: address.
- hwdata_s, input, 32: write data.
- hwrite_s, input, 1: 1 = write.
- htrans_s, input, 2: transfer type.
- hsize_s, input, 3: transfer size.
- hburst_s, input, 3: burst type; ignored.
- hsel_s, input, 1: slave select.
REQ-005 The block SHALL have AHB slave outputs:
- hrdata_s, output, 32: read data.
- hresp_s, output, 2: response, 00 = OKAY, 01 = ERROR.
- hready_s, output, 1: transfer done.
REQ-006 The block SHALL have APB4 requester outputs:
- paddr, output, 32: address.
- pwdata, output, 32: write data.
- pwrite, output, 1: 1 = write.
- pstrb, output, 4: byte strobes.
- psel, output, 1: select.
- penable, output, 1: enable.
REQ-007 The block SHALL have APB4 requester inputs:
- prdata, input, 32: read data.
- pready, input, 1: completer ready.
- pslverr, input, 1: completer error.

Function
REQ-008 A transfer SHALL be accepted when hsel_s=1, htrans_s is NONSEQ (10) or SEQ (11), and hready_s=1 in the same cycle; IDLE (00) and BUSY (01) SHALL be ignored and receive OKAY with no wait states.
REQ-009 On acceptance the block SHALL register haddr_s[apb_addr_w-1:0], hwrite_s, hsize_s[1:0] and haddr_s[1:0].
REQ-010 The FSM SHALL have states IDLE, WDATA, SETUP, ACCESS, and (with the feature enabled) ERR1 and ERR2.
REQ-011 In IDLE, an accepted write SHALL go to WDATA, an accepted read SHALL go to SETUP, and no acceptance SHALL stay in IDLE.
REQ-012 WDATA SHALL capture hwdata_s into pwdata, drive hready_s=0, and go to SETUP.
REQ-013 SETUP SHALL drive psel=1, penable=0, hready_s=0, and go to ACCESS.
REQ-014 ACCESS SHALL drive psel=1 and penable=1.
- While pready=0: hready_s=0 and the FSM stays in ACCESS.
- When pready=1: hready_s=1, hresp_s=00, and hrdata_s=prdata for reads.
REQ-015 On ACCESS completion with a new transfer accepted in that same cycle, the FSM SHALL go directly to WDATA or SETUP; otherwise it SHALL go to IDLE.
REQ-016 paddr, pwrite and pstrb SHALL stay stable from SETUP through the final ACCESS cycle, and pwdata SHALL stay stable from SETUP through completion.
REQ-017 pstrb SHALL be 0000 for reads; for writes it SHALL be:
- byte: 0001 shifted left by haddr[1:0].
- halfword: 0011 shifted left by 2*haddr[1].
- word (and any hsize_s>=2): 1111.
REQ-018 Outside a read completion cycle, hrdata_s SHALL be 0; psel and penable SHALL be 0 in IDLE and WDATA.
REQ-019 Latency SHALL be 3 cycles from the address phase to the data-phase hready_s=1 for a read with pready tied high, and 4 cycles for a write.

Reset
REQ-020 While hresetn=0 the FSM SHALL be IDLE, and every registered output SHALL be 0 except hready_s, which SHALL be 1.
REQ-021 Reset asserted mid-transfer SHALL abort immediately to IDLE with psel=0 and penable=0, and no APB completion SHALL be reported afterwards.

Configuration
REQ-022 With macro NF_AHB2APB_ERR_EN defined, pslverr=1 together with pready=1 in ACCESS SHALL produce the two-cycle AHB error response:
- ERR1: hready_s=0, hresp_s=01, psel=0.
- ERR2: hready_s=1, hresp_s=01.
- ERR2 accepts a new transfer exactly as IDLE does.
REQ-023 Without NF_AHB2APB_ERR_EN, pslverr SHALL be ignored, hresp_s SHALL always be 00, and the ERR1 and ERR2 states SHALL not exist.

Verification
REQ-024 The bench SHALL cover a word read: haddr_s=0x0000_0010, pready=1, prdata=0xDEAD_BEEF -> psel high for 2 cycles, paddr=0x10, hready_s=1 with hrdata_s=0xDEAD_BEEF in cycle 3.
REQ-025 The bench SHALL cover a byte write: haddr_s=0x0000_0023, hsize_s=000, hwdata_s=0x1122_3344 -> pstrb=1000, pwdata=0x1122_3344, pwrite=1, hresp_s=00.
REQ-026 The bench SHALL cover wait states: pready held 0 for 5 ACCESS cycles -> hready_s=0 throughout, and paddr and pwdata unchanged.
REQ-027 The bench SHALL cover back-to-back transfers: a read at 0x4 accepted in the completion cycle of a read at 0x0 -> no IDLE cycle between them; then htrans_s=BUSY -> ignored with OKAY.
REQ-028 The bench SHALL cover the error path with NF_AHB2APB_ERR_EN: pslverr=1 at completion -> hresp_s=01 for 2 cycles, hready_s 0 then 1; without the macro -> hresp_s=00.
REQ-029 The bench SHALL cover reset during ACCESS: hresetn=0 -> psel=0, penable=0, hready_s=1 asynchronously.
